thumb_fetch_unit: RTL and testbench

// - Instruction fetch/issue stage. Produces the 16-bit Thumb instruction stream that the cpuControl decoder consumes.
// - Consumes the decoder's brSel/brEx redirect outputs.
// - Sits between the instruction memory (req/ack handshake, one outstanding request) and the decode stage.
// - Holds a small prefetch FIFO; flushes on every taken redirect.

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/thumb_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_thumb_fetch_unit.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared types and constants for the Thumb fetch/decode path,
//            plus the branch-target helper used by the fetch unit.
// Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

  // Decoder branch selector encoding
  typedef enum logic [1:0] {
    BR_BL     = 2'b00,
    BR_COND   = 2'b01,
    BR_UNCOND = 2'b10,
    BR_SEQ    = 2'b11
  } brsel_e;

  // Fetch state machine encoding
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FETCH   = 2'b01,
    DISCARD = 2'b10
  } fetch_state_e;

  // Thumb NOP; what the decoder sees whenever no instruction is valid
  localparam logic [15:0] NOOP_INSTR = 16'hBF00;

  // Redirect target for an issued instruction; BX has priority over brSel.
  // PC-relative offsets are halfword counts, so they are sign-extended and
  // shifted left by one before being added to PC+4 (16-bit wrap).
  function automatic logic [15:0] branch_target(
    input logic [15:0] pc,
    input logic [15:0] instr,
    input brsel_e      sel,
    input logic        bx,
    input logic [15:0] bl_target,
    input logic [15:0] bx_target
  );
    if (bx) begin
      return {bx_target[15:1], 1'b0};
    end
    case (sel)
      BR_COND:   return pc + 16'd4 + {{7{instr[7]}}, instr[7:0], 1'b0};
      BR_UNCOND: return pc + 16'd4 + {{4{instr[10]}}, instr[10:0], 1'b0};
      default:   return bl_target;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small prefetch FIFO holding {pc, instr} entries. Head is read
//            combinationally; flush empties it and wins over push.
// Revision : 1.0  initial release
// ============================================================================
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  // A push into a full FIFO is accepted only when the head leaves that cycle
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage, pointers and occupancy; flush discards everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/thumb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : thumb_fetch_unit
// Purpose  : Thumb instruction fetch/issue stage. Fetches halfwords over a
//            single-outstanding req/ack port into a prefetch FIFO, issues the
//            FIFO head to decode and redirects on taken branches.
// Revision : 1.0  initial release
// ============================================================================
module thumb_fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [15:0] NOOP_INSTR = cpu_pkg::NOOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] PC,
  input  logic [1:0]  brSel,
  input  logic        brEx,
  input  logic [15:0] br_target,
  input  logic [15:0] bx_target
);

  import cpu_pkg::*;

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [15:0]  r_fetch_pc;
  logic [15:0]  w_fetch_pc_nxt;
  logic [15:0]  r_redir_pc;
  logic [15:0]  w_redir_pc_nxt;
  logic         w_req;
  logic         w_push;
  logic         w_full;
  logic         w_empty;
  logic [31:0]  w_head;
  logic         w_issue;
  logic         w_redirect;
  logic [15:0]  w_target;
  brsel_e       w_sel;

  assign w_sel      = brsel_e'(brSel);
  assign w_issue    = ~w_empty & instr_ready;
  assign w_redirect = w_issue & (brEx | (w_sel != BR_SEQ));
  assign w_target   = branch_target(w_head[31:16], w_head[15:0], w_sel, brEx,
                                    br_target, bx_target);

  assign imem_req    = w_req;
  assign imem_addr   = r_fetch_pc;
  assign instr_valid = ~w_empty;
  assign instr       = w_empty ? NOOP_INSTR : w_head[15:0];
  assign PC          = w_empty ? RESET_PC : w_head[31:16];

  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_data  ({r_fetch_pc, imem_rdata}),
    .i_pop   (w_issue),
    .i_flush (w_redirect),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Fetch state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch address and pending-redirect target registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_redir_pc <= RESET_PC;
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      r_redir_pc <= w_redir_pc_nxt;
    end
  end

  // Next-state, request and push decode. A redirect with no request in
  // flight (idle, or acked this very cycle) starts the target fetch at once;
  // with a request still outstanding the old response must be absorbed first.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_redir_pc_nxt = r_redir_pc;
    w_req          = 1'b0;
    w_push         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_redirect) begin
          w_fetch_pc_nxt = w_target;
          w_state_nxt    = FETCH;
        end else if (!w_full) begin
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        w_req = 1'b1;
        if (imem_ack) begin
          if (w_redirect) begin
            w_fetch_pc_nxt = w_target;
            w_state_nxt    = FETCH;
          end else begin
            w_push         = 1'b1;
            w_fetch_pc_nxt = r_fetch_pc + 16'd2;
            w_state_nxt    = IDLE;
          end
        end else if (w_redirect) begin
          w_redir_pc_nxt = w_target;
          w_state_nxt    = DISCARD;
        end
      end
      DISCARD: begin
        w_req = 1'b1;
        if (imem_ack) begin
          w_fetch_pc_nxt = r_redir_pc;
          w_state_nxt    = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_thumb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_thumb_fetch_unit
// Purpose  : Self-checking bench for thumb_fetch_unit: memory responder with
//            programmable ack delay, decoder driver and an issue-stream model.
// Revision : 1.0  initial release
// ============================================================================
module tb_thumb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] PC;
  logic [1:0]  brSel;
  logic        brEx;
  logic [15:0] br_target;
  logic [15:0] bx_target;

  int          vec;
  int          errs;
  int          n_issued;
  logic [15:0] mem [0:32767];
  logic [15:0] exp_pc;
  int          dly_min;
  int          dly_max;
  bit          rsp_en;

  thumb_fetch_unit #(
    .RESET_PC   (16'h0000),
    .FIFO_DEPTH (2),
    .NOOP_INSTR (16'hBF00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .PC          (PC),
    .brSel       (brSel),
    .brEx        (brEx),
    .br_target   (br_target),
    .bx_target   (bx_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Where the next issued instruction must come from, computed from the
  // architectural branch rules with plain integer arithmetic.
  function automatic logic [15:0] model_target(input logic [15:0] cur,
      input logic [15:0] ins, input logic [1:0] sel, input logic ex,
      input logic [15:0] bt, input logic [15:0] bxt);
    int off;
    int s;
    if (ex) return bxt & 16'hFFFE;
    case (sel)
      2'b01: begin
        off = int'($signed(ins[7:0]));
        s   = int'(cur) + 4 + 2 * off;
        return s[15:0];
      end
      2'b10: begin
        off = int'($signed(ins[10:0]));
        s   = int'(cur) + 4 + 2 * off;
        return s[15:0];
      end
      default: return bt;
    endcase
  endfunction

  // Instruction memory responder: acks after a chosen delay, returns garbage
  // on non-ack cycles, and checks the address holds while a request waits.
  initial begin : responder
    int          cnt;
    int          dly;
    bit          pend;
    logic [15:0] pend_addr;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    cnt        = 0;
    dly        = 0;
    pend       = 1'b0;
    pend_addr  = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rsp_en) begin
        cnt  = 0;
        pend = 1'b0;
      end else if (!reset || !imem_req) begin
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        cnt        = 0;
        pend       = 1'b0;
      end else begin
        if (pend) begin
          vec++;
          if (imem_addr !== pend_addr) begin
            errs++;
            $display("FAIL addr_stable: imem_addr=%h required %h", imem_addr, pend_addr);
          end
        end
        if (cnt >= dly) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr[15:1]];
          cnt        = 0;
          dly        = int'($urandom_range(dly_max, dly_min));
          pend       = 1'b0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 16'($urandom);
          cnt++;
          pend       = 1'b1;
          pend_addr  = imem_addr;
        end
      end
    end
  end

  // One decode cycle: called at a negedge, drives the decoder inputs and
  // scores the issue handshake that completes at the following posedge.
  task automatic step(input logic rdy, input logic [1:0] sel, input logic ex,
                      input logic [15:0] bt, input logic [15:0] bxt);
    logic [15:0] cur;
    logic [15:0] ins;
    if (!instr_valid) begin
      vec++;
      if (instr !== 16'hBF00) begin
        errs++;
        $display("FAIL noop_when_invalid: instr=%h required bf00", instr);
      end
    end
    instr_ready = rdy;
    brSel       = sel;
    brEx        = ex;
    br_target   = bt;
    bx_target   = bxt;
    if (instr_valid && rdy) begin
      cur = exp_pc;
      ins = mem[cur[15:1]];
      vec++;
      if (PC !== cur || instr !== ins) begin
        errs++;
        $display("FAIL issue_stream: PC=%h instr=%h required PC=%h instr=%h", PC, instr, cur, ins);
      end
      n_issued++;
      if (ex || sel != 2'b11) exp_pc = model_target(cur, ins, sel, ex, bt, bxt);
      else                    exp_pc = cur + 16'd2;
    end
    @(negedge clk);
  endtask

  task automatic wait_valid(input int max_cycles, input string tag);
    int n;
    n = 0;
    while (!instr_valid && n < max_cycles) begin
      step(1'b0, 2'b11, 1'b0, 16'h0, 16'h0);
      n++;
    end
    vec++;
    if (!instr_valid) begin
      errs++;
      $display("FAIL %s_timeout: instr_valid=%b required 1 within %0d cycles", tag, instr_valid, max_cycles);
    end
  endtask

  task automatic wait_req(input int max_cycles, input string tag);
    int n;
    n = 0;
    while (!imem_req && n < max_cycles) begin
      step(1'b0, 2'b11, 1'b0, 16'h0, 16'h0);
      n++;
    end
    vec++;
    if (!imem_req) begin
      errs++;
      $display("FAIL %s_req_timeout: imem_req=%b required 1", tag, imem_req);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    rsp_en      = 1'b1;
    instr_ready = 1'b0;
    brSel       = 2'b11;
    brEx        = 1'b0;
    br_target   = 16'h0;
    bx_target   = 16'h0;
    repeat (2) @(negedge clk);
    exp_pc   = 16'h0000;
    n_issued = 0;
    reset    = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    vec++;
    if (imem_req !== 1'b0) begin errs++; $display("FAIL %s_req: imem_req=%b required 0", tag, imem_req); end
    vec++;
    if (imem_addr !== 16'h0000) begin errs++; $display("FAIL %s_addr: imem_addr=%h required 0000", tag, imem_addr); end
    vec++;
    if (instr_valid !== 1'b0) begin errs++; $display("FAIL %s_valid: instr_valid=%b required 0", tag, instr_valid); end
    vec++;
    if (instr !== 16'hBF00) begin errs++; $display("FAIL %s_instr: instr=%h required bf00", tag, instr); end
    vec++;
    if (PC !== 16'h0000) begin errs++; $display("FAIL %s_pc: PC=%h required 0000", tag, PC); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
  endtask

  task automatic test_sequential();
    dly_min = 0; dly_max = 0;
    do_reset();
    repeat (16) step(1'b1, 2'b11, 1'b0, 16'h0, 16'h0);
    vec++;
    if (n_issued < 6 || exp_pc < 16'd12) begin
      errs++;
      $display("FAIL seq_progress: issued=%0d next_pc=%h required >=6 issued", n_issued, exp_pc);
    end
  endtask

  task automatic test_stall();
    logic [15:0] pc0;
    logic [15:0] in0;
    wait_valid(20, "stall");
    pc0 = PC;
    in0 = instr;
    repeat (5) begin
      step(1'b0, 2'b11, 1'b0, 16'h0, 16'h0);
      vec++;
      if (!instr_valid || PC !== pc0 || instr !== in0) begin
        errs++;
        $display("FAIL stall_hold: valid=%b PC=%h instr=%h required 1 %h %h", instr_valid, PC, instr, pc0, in0);
      end
    end
    vec++;
    if (imem_req !== 1'b0) begin
      errs++;
      $display("FAIL stall_full_noreq: imem_req=%b required 0", imem_req);
    end
    repeat (20) step(1'b1, 2'b11, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_beq();
    int n;
    dly_min = 0; dly_max = 0;
    mem[16'h0010 >> 1] = 16'hD0FE;
    do_reset();
    n = 0;
    while (!(instr_valid && PC == 16'h0010) && n < 100) begin
      step(1'b1, 2'b11, 1'b0, 16'h0, 16'h0);
      n++;
    end
    step(1'b1, 2'b01, 1'b0, 16'h0, 16'h0);
    wait_valid(20, "beq");
    vec++;
    if (PC !== 16'h0010) begin
      errs++;
      $display("FAIL beq_target: PC=%h required 0010", PC);
    end
    repeat (6) step(1'b1, 2'b11, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_b_bx();
    dly_min = 0; dly_max = 0;
    mem[0] = 16'hE7FF;
    do_reset();
    wait_valid(20, "b");
    vec++;
    if (PC !== 16'h0000) begin errs++; $display("FAIL b_first_pc: PC=%h required 0000", PC); end
    step(1'b1, 2'b10, 1'b0, 16'h0, 16'h0);
    wait_valid(20, "b");
    vec++;
    if (PC !== 16'h0002) begin errs++; $display("FAIL b_target: PC=%h required 0002", PC); end
    step(1'b1, 2'b11, 1'b1, 16'h0, 16'h0101);
    vec++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0100 || instr_valid !== 1'b0) begin
      errs++;
      $display("FAIL bx_latency_req: req=%b addr=%h valid=%b required 1 0100 0", imem_req, imem_addr, instr_valid);
    end
    step(1'b0, 2'b11, 1'b0, 16'h0, 16'h0);
    vec++;
    if (instr_valid !== 1'b1 || PC !== 16'h0100) begin
      errs++;
      $display("FAIL bx_latency_issue: valid=%b PC=%h required 1 0100", instr_valid, PC);
    end
    repeat (6) step(1'b1, 2'b11, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_discard();
    logic [15:0] a0;
    dly_min = 3; dly_max = 3;
    do_reset();
    wait_valid(40, "discard");
    wait_req(20, "discard");
    a0 = imem_addr;
    step(1'b1, 2'b00, 1'b0, 16'h0200, 16'h0);
    vec++;
    if (imem_req !== 1'b1 || imem_addr !== a0 || instr_valid !== 1'b0) begin
      errs++;
      $display("FAIL discard_hold: req=%b addr=%h valid=%b required 1 %h 0", imem_req, imem_addr, instr_valid, a0);
    end
    wait_valid(40, "discard");
    vec++;
    if (PC !== 16'h0200 || instr !== mem[16'h0100]) begin
      errs++;
      $display("FAIL discard_first: PC=%h instr=%h required 0200 %h", PC, instr, mem[16'h0100]);
    end
    repeat (12) step(1'b1, 2'b11, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_reset_mid();
    dly_min = 3; dly_max = 3;
    do_reset();
    wait_req(20, "midrst");
    #2;
    rsp_en   = 1'b0;
    imem_ack = 1'b0;
    reset    = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    reset      = 1'b1;
    exp_pc     = 16'h0000;
    imem_ack   = 1'b1;
    imem_rdata = 16'h1234;
    @(negedge clk);
    imem_ack = 1'b0;
    vec++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
      errs++;
      $display("FAIL midrst_refetch: req=%b addr=%h valid=%b required 1 0000 0", imem_req, imem_addr, instr_valid);
    end
    rsp_en = 1'b1;
    wait_valid(40, "midrst");
    vec++;
    if (PC !== 16'h0000 || instr !== mem[0]) begin
      errs++;
      $display("FAIL midrst_first: PC=%h instr=%h required 0000 %h", PC, instr, mem[0]);
    end
    repeat (8) step(1'b1, 2'b11, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_random();
    logic       rdy;
    logic [1:0] sel;
    logic       ex;
    dly_min = 0; dly_max = 3;
    do_reset();
    repeat (3000) begin
      rdy = ($urandom_range(0, 3) != 0);
      sel = ($urandom_range(0, 9) < 6) ? 2'b11 : 2'($urandom_range(0, 2));
      ex  = ($urandom_range(0, 15) == 0);
      step(rdy, sel, ex, 16'($urandom), 16'($urandom));
    end
    vec++;
    if (n_issued < 200) begin
      errs++;
      $display("FAIL random_progress: issued=%0d required >=200", n_issued);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec         = 0;
    errs        = 0;
    n_issued    = 0;
    exp_pc      = 16'h0000;
    dly_min     = 0;
    dly_max     = 0;
    rsp_en      = 1'b1;
    reset       = 1'b0;
    instr_ready = 1'b0;
    brSel       = 2'b11;
    brEx        = 1'b0;
    br_target   = 16'h0;
    bx_target   = 16'h0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    test_reset();
    test_sequential();
    test_stall();
    test_beq();
    test_b_bx();
    test_discard();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
`default_nettype wire
